// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: single-word fetch port, whole-line refill
// from a word-wide backing memory, flush, and saturating hit/miss counters.
module icache_dm #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              misalign,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int RAM_AW = IDX_W + WSEL_W;
  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t              state_reg, state_next;
  logic [WSEL_W-1:0]   fill_cnt_reg, fill_cnt_next;
  logic                pend_flush_reg, pend_flush_next;
  logic [LINE_W-1:0]   cap_line_reg, cap_line_next;
  logic [WSEL_W-1:0]   cap_wsel_reg, cap_wsel_next;
  logic                inst_valid_reg, inst_valid_next;
  logic                misalign_reg, misalign_next;
  logic [15:0]         hit_cnt_reg, hit_cnt_next;
  logic [15:0]         miss_cnt_reg, miss_cnt_next;

  logic [NUM_LINES-1:0] valid_reg;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
  logic [31:0]          rd_data_reg;

  logic                rd_en;
  logic [RAM_AW-1:0]   rd_addr;
  logic                data_we;
  logic                line_fill;
  logic                line_evict;
  logic                clear_all;
  logic                accept;
  logic                hit;

  logic [WSEL_W-1:0]   pc_wsel;
  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [IDX_W-1:0]    cap_idx;
  logic [TAG_W-1:0]    cap_tag;

  assign pc_wsel = pc[OFF_W-1:2];
  assign pc_idx  = pc[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag  = pc[ADDR_W-1:OFF_W+IDX_W];
  assign cap_idx = cap_line_reg[IDX_W-1:0];
  assign cap_tag = cap_line_reg[LINE_W-1:IDX_W];

  // rst_n gates ready directly so nothing is accepted while reset is held
  assign req_ready = rst_n && (state_reg == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign hit       = valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  always_comb begin
    state_next      = state_reg;
    fill_cnt_next   = fill_cnt_reg;
    pend_flush_next = pend_flush_reg;
    cap_line_next   = cap_line_reg;
    cap_wsel_next   = cap_wsel_reg;
    inst_valid_next = 1'b0;
    misalign_next   = 1'b0;
    hit_cnt_next    = hit_cnt_reg;
    miss_cnt_next   = miss_cnt_reg;
    rd_en           = 1'b0;
    rd_addr         = {pc_idx, pc_wsel};
    data_we         = 1'b0;
    line_fill       = 1'b0;
    line_evict      = 1'b0;
    clear_all       = 1'b0;
    mem_req         = 1'b0;
    mem_addr        = '0;
    unique case (state_reg)
      IDLE: begin
        if (flush) begin
          clear_all = 1'b1;
        end else if (accept) begin
          if (pc[1:0] != 2'b00) begin
            inst_valid_next = 1'b1;
            misalign_next   = 1'b1;
          end else if (hit) begin
            inst_valid_next = 1'b1;
            rd_en           = 1'b1;
            hit_cnt_next    = (hit_cnt_reg == 16'hFFFF) ? hit_cnt_reg : hit_cnt_reg + 16'd1;
          end else begin
            cap_line_next = pc[ADDR_W-1:OFF_W];
            cap_wsel_next = pc_wsel;
            fill_cnt_next = '0;
            line_evict    = 1'b1;
            miss_cnt_next = (miss_cnt_reg == 16'hFFFF) ? miss_cnt_reg : miss_cnt_reg + 16'd1;
            state_next    = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {cap_line_reg, fill_cnt_reg, 2'b00};
        if (flush) pend_flush_next = 1'b1;
        if (mem_rvalid) begin
          data_we       = 1'b1;
          fill_cnt_next = fill_cnt_reg + WSEL_W'(1);
          if (fill_cnt_reg == LAST_WORD) begin
            line_fill  = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        // the refilled word is read here; a deferred flush lands on the way back to IDLE
        rd_en           = 1'b1;
        rd_addr         = {cap_idx, cap_wsel_reg};
        inst_valid_next = 1'b1;
        clear_all       = flush || pend_flush_reg;
        pend_flush_next = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fill_cnt_reg   <= '0;
      pend_flush_reg <= 1'b0;
      cap_line_reg   <= '0;
      cap_wsel_reg   <= '0;
      inst_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      fill_cnt_reg   <= fill_cnt_next;
      pend_flush_reg <= pend_flush_next;
      cap_line_reg   <= cap_line_next;
      cap_wsel_reg   <= cap_wsel_next;
      inst_valid_reg <= inst_valid_next;
      misalign_reg   <= misalign_next;
      hit_cnt_reg    <= hit_cnt_next;
      miss_cnt_reg   <= miss_cnt_next;
    end
  end

  // a line is invalidated when its refill starts, so an aborted fill never looks valid
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     valid_reg[gi] <= 1'b0;
        else if (clear_all)                             valid_reg[gi] <= 1'b0;
        else if (line_fill && cap_idx == IDX_W'(gi))    valid_reg[gi] <= 1'b1;
        else if (line_evict && pc_idx == IDX_W'(gi))    valid_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (line_fill) tag_mem[cap_idx] <= cap_tag;
    if (data_we)   data_mem[{cap_idx, fill_cnt_reg}] <= mem_rdata;
    if (rd_en)     rd_data_reg <= data_mem[rd_addr];
  end

  assign inst_valid = inst_valid_reg;
  assign misalign   = misalign_reg;
  assign inst       = (inst_valid_reg && !misalign_reg) ? rd_data_reg : 32'h0;
  assign hit_cnt    = hit_cnt_reg;
  assign miss_cnt   = miss_cnt_reg;
endmodule
